// File: rtl/fir_tap_pipe.sv
// ---------------------------------------------------------------------------
// fir_tap_pipe
//
// A pipelined direct-form FIR filter stage. It takes one signed sample per
// din_valid, which may be high on every cycle, and produces
// sum(x[k] * c[k]) at full precision. The result is never rounded or
// saturated. The coefficients are written at run time through a small
// write port.
//
// Pipeline (one register per stage):
//   S0               delay line x[0..TAPS-1], shifts only when din_valid is high
//   S1               TAPS products p[k] = x[k] * c[k]
//   S2..S(1+ADDR_W)  binary adder tree, one level per stage, +1 bit per level
//   The last tree level is the dout register. It loads only when a valid
//   sample reaches it and holds its value otherwise.
//   Latency: din_valid sampled at edge E gives dout_valid after edge
//   E+1+ADDR_W.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset, clears all state
//   din        signed input sample
//   din_valid  input sample qualifier
//   coef_we    coefficient write strobe
//   coef_addr  tap index to write (0 = newest sample)
//   coef_data  signed coefficient value
//   dout       signed filtered sample (full precision)
//   dout_valid one-cycle pulse per accepted input sample
// ---------------------------------------------------------------------------
module fir_tap_pipe #(
  parameter int DATA_W = 12,
  parameter int COEF_W = 12,
  parameter int TAPS   = 8,
  parameter int ADDR_W = $clog2(TAPS),
  parameter int OUT_W  = DATA_W + COEF_W + ADDR_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [DATA_W-1:0] din,
  input  logic                     din_valid,
  input  logic                     coef_we,
  input  logic        [ADDR_W-1:0] coef_addr,
  input  logic signed [COEF_W-1:0] coef_data,
  output logic signed [OUT_W-1:0]  dout,
  output logic                     dout_valid
);

  localparam int PROD_W  = DATA_W + COEF_W;
  localparam int LATENCY = 2 + ADDR_W;

  // Full-width signed product. Both operands are sign-extended explicitly,
  // so the multiply is exactly PROD_W bits wide and cannot overflow.
  function automatic logic signed [PROD_W-1:0] mul_full(
    input logic signed [DATA_W-1:0] a,
    input logic signed [COEF_W-1:0] b
  );
    logic signed [PROD_W-1:0] a_ext;
    logic signed [PROD_W-1:0] b_ext;
    a_ext = {{COEF_W{a[DATA_W-1]}}, a};
    b_ext = {{DATA_W{b[COEF_W-1]}}, b};
    return a_ext * b_ext;
  endfunction

  // -------------------------------------------------------------------------
  // S0: sample delay line
  // -------------------------------------------------------------------------
  logic signed [DATA_W-1:0] x_q [TAPS];

  // NOTE: sequential state always uses non-blocking (<=) so every register
  // samples the pre-edge values of the others; with '=' the shift would
  // collapse into a single copy.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < TAPS; k++) x_q[k] <= '0;
    end else if (din_valid) begin
      x_q[0] <= din;
      for (int k = 1; k < TAPS; k++) x_q[k] <= x_q[k-1];
    end
  end

  // -------------------------------------------------------------------------
  // Coefficient store
  // -------------------------------------------------------------------------
  logic signed [COEF_W-1:0] c_q [TAPS];

  // NOTE: this small array is a bank of flops, not a RAM macro. It is reset
  // element by element because the filter must start from all-zero taps.
  // Do not reset arrays that are meant to map onto block RAM.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < TAPS; k++) c_q[k] <= '0;
    end else if (coef_we) begin
      // TAPS is a power of two, so every coef_addr is a real tap.
      c_q[coef_addr] <= coef_data;
    end
  end

  // -------------------------------------------------------------------------
  // Valid pipeline: vld_q[i] marks a sample that has just passed stage Si.
  // -------------------------------------------------------------------------
  logic [LATENCY-1:0] vld_q;

  always_ff @(posedge clk) begin
    if (rst) vld_q <= '0;
    else     vld_q <= {vld_q[LATENCY-2:0], din_valid};
  end

  assign dout_valid = vld_q[LATENCY-1];

  // -------------------------------------------------------------------------
  // S1: products. These use the coefficients held before the edge, so a
  // write at edge E first shows up in the products registered at E+1.
  // -------------------------------------------------------------------------
  logic signed [PROD_W-1:0] prod_d [TAPS];
  logic signed [PROD_W-1:0] prod_q [TAPS];

  // NOTE: every element is assigned on every pass through the block, so
  // always_comb cannot infer a latch. Any partially assigned output would
  // infer one.
  always_comb begin
    for (int k = 0; k < TAPS; k++) prod_d[k] = mul_full(x_q[k], c_q[k]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < TAPS; k++) prod_q[k] <= '0;
    end else begin
      prod_q <= prod_d;
    end
  end

  // -------------------------------------------------------------------------
  // S2..S(1+ADDR_W): adder tree. Level l has TAPS>>(l+1) nodes, each
  // PROD_W+l+1 bits wide. Each operand is sign-extended by one bit, so no
  // sum can wrap. Inner levels run freely. The final level is dout and
  // loads only when the valid bit for its input stage is set.
  // -------------------------------------------------------------------------
  for (genvar l = 0; l < ADDR_W; l++) begin : g_lvl
    localparam int W = PROD_W + l + 1;
    localparam int N = TAPS >> (l + 1);

    logic signed [W-1:0] sum_d [N];
    logic signed [W-1:0] sum_q [N];
    logic                en;

    if (l == 0) begin : g_src
      always_comb begin
        for (int n = 0; n < N; n++) begin
          sum_d[n] = {prod_q[2*n][PROD_W-1],   prod_q[2*n]}
                   + {prod_q[2*n+1][PROD_W-1], prod_q[2*n+1]};
        end
      end
    end else begin : g_src
      always_comb begin
        for (int n = 0; n < N; n++) begin
          sum_d[n] = {g_lvl[l-1].sum_q[2*n][W-2],   g_lvl[l-1].sum_q[2*n]}
                   + {g_lvl[l-1].sum_q[2*n+1][W-2], g_lvl[l-1].sum_q[2*n+1]};
        end
      end
    end

    if (l == ADDR_W - 1) begin : g_gate
      // The stage feeding the output register is S(ADDR_W).
      assign en = vld_q[ADDR_W];
    end else begin : g_free
      assign en = 1'b1;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int n = 0; n < N; n++) sum_q[n] <= '0;
      end else if (en) begin
        sum_q <= sum_d;
      end
    end
  end

  assign dout = g_lvl[ADDR_W-1].sum_q[0];

endmodule

// File: tb/tb_fir_tap_pipe.sv
// ---------------------------------------------------------------------------
// tb_fir_tap_pipe
//
// Testbench for fir_tap_pipe with TAPS=8.
// The stimulus process pushes the hand-computed output for each sample into
// a scoreboard, together with the edge count at which that output must
// appear. The monitor runs on the falling edge and compares the outputs:
//   - cycles after a reset edge must show dout=0 and dout_valid=0;
//   - a dout_valid pulse pops the scoreboard and checks the value and timing;
//   - any other cycle must show dout holding the last expected output.
// ---------------------------------------------------------------------------
module tb_fir_tap_pipe;

  localparam int DATA_W = 12;
  localparam int COEF_W = 12;
  localparam int TAPS   = 8;
  localparam int ADDR_W = 3;
  localparam int OUT_W  = 27;
  localparam int LAT    = 5;

  logic                     clk = 1'b0;
  logic                     rst;
  logic signed [DATA_W-1:0] din;
  logic                     din_valid;
  logic                     coef_we;
  logic        [ADDR_W-1:0] coef_addr;
  logic signed [COEF_W-1:0] coef_data;
  logic signed [OUT_W-1:0]  dout;
  logic                     dout_valid;

  fir_tap_pipe #(
    .DATA_W(DATA_W),
    .COEF_W(COEF_W),
    .TAPS  (TAPS),
    .ADDR_W(ADDR_W),
    .OUT_W (OUT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .din_valid (din_valid),
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .dout      (dout),
    .dout_valid(dout_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic signed [OUT_W-1:0] val;
    int                      edge_no;
  } exp_t;

  exp_t                    sb[$];
  exp_t                    mon_e;
  int                      total    = 0;
  int                      bad      = 0;
  int                      edge_n   = 0;
  bit                      rst_seen = 1'b0;
  logic signed [OUT_W-1:0] hold_ref = '0;
  string                   cur_test = "init";

  always @(posedge clk) begin
    edge_n   <= edge_n + 1;
    rst_seen <= rst;
  end

  task automatic check(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s/%s: actual=%0d required=%0d", cur_test, name, act, req);
    end
  endtask

  // Monitor: decoupled from the stimulus, driven by DUT outputs only.
  always @(negedge clk) begin
    if (rst_seen) begin
      check("reset_dout", dout, 0);
      check("reset_valid", {63'd0, dout_valid}, 0);
      hold_ref = '0;
    end else if (dout_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_valid", {63'd0, dout_valid}, 0);
      end else begin
        mon_e = sb.pop_front();
        check("dout_value", dout, mon_e.val);
        check("dout_timing", edge_n, mon_e.edge_no);
        hold_ref = mon_e.val;
      end
    end else begin
      check("dout_hold", dout, hold_ref);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic wr(input int a, input int v);
    coef_we   = 1'b1;
    coef_addr = a[ADDR_W-1:0];
    coef_data = v[COEF_W-1:0];
    step();
    coef_we   = 1'b0;
  endtask

  task automatic wr_all(input int v);
    for (int k = 0; k < TAPS; k++) wr(k, v);
  endtask

  // Drive one sample. The edge that samples it is edge_n+1, so its output
  // must appear after edge edge_n+1+(LAT-1).
  task automatic smp(input int d, input longint e);
    exp_t t;
    t.val     = e[OUT_W-1:0];
    t.edge_no = edge_n + LAT;
    sb.push_back(t);
    din       = d[DATA_W-1:0];
    din_valid = 1'b1;
    step();
    din_valid = 1'b0;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    idle(n);
    sb.delete();
    rst = 1'b0;
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while (sb.size() != 0 && budget < 40) begin
      step();
      budget++;
    end
    if (sb.size() != 0) begin
      check("drain_timeout", sb.size(), 0);
      sb.delete();
    end
    idle(3);
  endtask

  initial begin
    rst       = 1'b1;
    din       = '0;
    din_valid = 1'b0;
    coef_we   = 1'b0;
    coef_addr = '0;
    coef_data = '0;

    // 1: reset with random activity on every input
    cur_test = "reset";
    for (int i = 0; i < 3; i++) begin
      din       = DATA_W'($urandom);
      din_valid = 1'($urandom);
      coef_we   = 1'($urandom);
      coef_addr = ADDR_W'($urandom);
      coef_data = COEF_W'($urandom);
      step();
      check("in_reset_dout", dout, 0);
      check("in_reset_valid", {63'd0, dout_valid}, 0);
    end
    rst       = 1'b0;
    din_valid = 1'b0;
    coef_we   = 1'b0;
    step();
    check("release_dout", dout, 0);
    check("release_valid", {63'd0, dout_valid}, 0);
    idle(6);

    // 2: impulse response, one sample every second cycle, c[k] = k+1
    cur_test = "impulse";
    for (int k = 0; k < TAPS; k++) wr(k, k + 1);
    smp(1, 1);
    idle(1);
    for (int i = 1; i < 10; i++) begin
      smp(0, (i < 8) ? i + 1 : 0);
      idle(1);
    end
    drain();

    // 3: extreme values
    cur_test = "extreme_neg_neg";
    do_reset(1);
    wr_all(-2048);
    for (int n = 1; n <= 8; n++) smp(-2048, longint'(n) * 4194304);
    drain();
    cur_test = "extreme_pos_neg";
    wr_all(2047);
    for (int n = 1; n <= 8; n++) smp(-2048, -33538048);
    drain();

    // 4: back-to-back streaming ramps to 800 and holds there
    cur_test = "stream";
    do_reset(1);
    wr_all(1);
    for (int n = 1; n <= 12; n++) smp(100, ((n < 8) ? n : 8) * 100);
    drain();

    // 5: coefficient write in the middle of a stream
    cur_test = "coef_update";
    do_reset(1);
    wr_all(1);
    for (int n = 1; n <= 12; n++) smp(1, (n < 8) ? n : 8);
    // The write and sample 13 are sampled at the same edge. Sample 13 reaches
    // S1 one edge later, so it already sees c[3]=5. Sample 12 does not.
    coef_we   = 1'b1;
    coef_addr = 3'd3;
    coef_data = 12'sd5;
    smp(1, 12);
    coef_we   = 1'b0;
    for (int n = 14; n <= 16; n++) smp(1, 12);
    drain();

    // 6: reset with three samples in flight
    cur_test = "reset_mid";
    do_reset(1);
    wr_all(1);
    smp(5, 5);
    smp(5, 10);
    smp(5, 15);
    do_reset(1);
    idle(4);
    smp(7, 0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
